// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  // Packet FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // err_o codes
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         BAUD_DEFAULT = 521;

endpackage

// File: rtl/uart_loader_rx.sv
// UART byte receiver: synchroniser, glitch-rejecting start detect,
// mid-bit sampling (LSB first) and stop-bit framing check.
module uart_rx_sampled
  import uart_loader_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int BAUD     = BAUD_DEFAULT,
  parameter int CW       = 10
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                rx_i,
  output logic [DATA_LEN-1:0] byte_o,
  output logic                byte_valid_o,
  output logic                frame_err_o,
  output logic                rx_idle_o
);

  localparam int            BW      = $clog2(DATA_LEN + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

  logic [1:0]          sync;
  logic                rx_s;
  logic                rx_prev;
  rx_state_t           st;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bits;
  logic [DATA_LEN-1:0] shreg;

  assign rx_s      = sync[1];
  assign byte_o    = shreg;
  assign rx_idle_o = (st == RX_IDLE);

  // Two-flop synchroniser plus edge history; idles high like the line
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx_i};
      rx_prev <= rx_s;
    end
  end

  // Frame sequencer; a start that is high again at mid-bit is dropped silently
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      st           <= RX_IDLE;
      cnt          <= '0;
      bits         <= '0;
      shreg        <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt  <= '0;
            bits <= '0;
            st   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_LEN-1:1]};
            if (bits == BW'(DATA_LEN - 1)) st <= RX_STOP;
            else bits <= bits + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s) byte_valid_o <= 1'b1;
            else      frame_err_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Packet loader: parses SYNC/START/COUNT/data/CHECKSUM packets from the
// UART receiver and streams DATA_WIDTH words into the memory write port.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                          DATA_WIDTH                 = 4,
  parameter int                          ADDR_WIDTH                 = 4,
  parameter int                          UART_DATA_LENGTH           = 8,
  parameter int                          BAUD_COUNTS_PER_BIT        = BAUD_DEFAULT,
  parameter int                          BAUD_RATE_COUNTER_BITWIDTH = 10,
  parameter logic [UART_DATA_LENGTH-1:0] SYNC_BYTE                  = UART_DATA_LENGTH'(SYNC_DEFAULT),
  parameter int                          TIMEOUT_BITS               = 40
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  p_program_i,
  input  logic                  rx_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  program_o,
  output logic                  busy_o,
  output logic                  done_strb_o,
  output logic [1:0]            err_o
);

  localparam int WPB      = UART_DATA_LENGTH / DATA_WIDTH;
  localparam int SW       = (WPB > 1) ? $clog2(WPB) + 1 : 1;
  localparam int WLW      = (ADDR_WIDTH + 1 > UART_DATA_LENGTH) ? ADDR_WIDTH + 1 : UART_DATA_LENGTH;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_COUNTS_PER_BIT;
  localparam int TOW      = $clog2(TO_LIMIT + 1);

  logic [UART_DATA_LENGTH-1:0] rx_byte;
  logic                        rx_valid;
  logic                        rx_ferr;
  logic                        rx_idle;

  state_t                      state;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [WLW-1:0]              words_left;
  logic [SW-1:0]               slices_left;
  logic [UART_DATA_LENGTH-1:0] shreg;
  logic [UART_DATA_LENGTH-1:0] csum;
  logic [TOW-1:0]              tcnt;
  logic                        timeout;

  uart_rx_sampled #(
    .DATA_LEN (UART_DATA_LENGTH),
    .BAUD     (BAUD_COUNTS_PER_BIT),
    .CW       (BAUD_RATE_COUNTER_BITWIDTH)
  ) u_rx (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr),
    .rx_idle_o    (rx_idle)
  );

  assign busy_o  = (state != S_IDLE);
  assign timeout = busy_o && rx_idle && !rx_valid && (tcnt == TOW'(TO_LIMIT - 1));

  // Inter-byte idle counter; only runs while a packet is open and the line is quiet
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) tcnt <= '0;
    else if (!busy_o || !rx_idle || rx_valid) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  // Packet FSM: abort beats timeout beats framing beats normal byte handling.
  // The first word of a byte is issued straight from DATA so the write lands
  // the cycle after byte_valid; WRITE issues the remaining slices.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= S_IDLE;
      waddr       <= '0;
      words_left  <= '0;
      slices_left <= '0;
      shreg       <= '0;
      csum        <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      program_o   <= 1'b0;
      done_strb_o <= 1'b0;
      err_o       <= ERR_NONE;
    end else begin
      program_o   <= p_program_i;
      mem_we_o    <= 1'b0;
      done_strb_o <= 1'b0;
      if (!p_program_i) begin
        if (busy_o) err_o <= ERR_ABORT;
        state <= S_IDLE;
      end else if (timeout) begin
        err_o <= ERR_ABORT;
        state <= S_IDLE;
      end else if (rx_ferr) begin
        err_o <= ERR_FRAME;
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (rx_valid && rx_byte == SYNC_BYTE) state <= S_ADDR;
          S_ADDR: if (rx_valid) begin
            waddr <= rx_byte[ADDR_WIDTH-1:0];
            csum  <= rx_byte;
            state <= S_CNT;
          end
          S_CNT: if (rx_valid) begin
            csum       <= csum + rx_byte;
            words_left <= (rx_byte == '0) ? WLW'(2 ** ADDR_WIDTH) : WLW'(rx_byte);
            state      <= S_DATA;
          end
          S_DATA: if (rx_valid) begin
            csum        <= csum + rx_byte;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= waddr;
            mem_data_o  <= rx_byte[UART_DATA_LENGTH-1 -: DATA_WIDTH];
            waddr       <= waddr + 1'b1;
            words_left  <= words_left - 1'b1;
            shreg       <= rx_byte << DATA_WIDTH;
            slices_left <= SW'(WPB - 1);
            if (words_left == WLW'(1)) state <= S_CSUM;
            else if (WPB == 1)         state <= S_DATA;
            else                       state <= S_WRITE;
          end
          S_WRITE: begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= waddr;
            mem_data_o  <= shreg[UART_DATA_LENGTH-1 -: DATA_WIDTH];
            waddr       <= waddr + 1'b1;
            words_left  <= words_left - 1'b1;
            shreg       <= shreg << DATA_WIDTH;
            slices_left <= slices_left - 1'b1;
            if (words_left == WLW'(1))       state <= S_CSUM;
            else if (slices_left == SW'(1))  state <= S_DATA;
          end
          S_CSUM: if (rx_valid) begin
            if (rx_byte == csum) begin
              done_strb_o <= 1'b1;
              err_o       <= ERR_NONE;
            end else begin
              err_o <= ERR_CSUM;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: packets are turned into an expected
// write list by a word-level model; a monitor pops it on every mem_we_o.
module tb_uart_loader;

  localparam int DW = 4, AW = 4, UDL = 8, BAUD = 16, TOB = 40, WPB = UDL / DW;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          p_program_i = 1'b0;
  logic          rx_i = 1'b1;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          program_o;
  logic          busy_o;
  logic          done_strb_o;
  logic [1:0]    err_o;

  uart_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UART_DATA_LENGTH(UDL),
    .BAUD_COUNTS_PER_BIT(BAUD), .BAUD_RATE_COUNTER_BITWIDTH(10),
    .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .p_program_i(p_program_i), .rx_i(rx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .program_o(program_o), .busy_o(busy_o), .done_strb_o(done_strb_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mw;
  logic [7:0] pkt[$];
  int         checks = 0, errors = 0;
  int         done_seen = 0, exp_done = 0;
  logic [1:0] exp_err = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard
  always @(negedge clk_i) begin
    if (reset_i && mem_we_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h@%0h required=none", mem_data_o, mem_addr_o);
      end else begin
        mw = exp_q.pop_front();
        chk("wr_addr", mem_addr_o, mw.addr);
        chk("wr_data", mem_data_o, mw.data);
      end
    end
  end

  // Done strobe counter
  always @(negedge clk_i) if (done_strb_o) done_seen++;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (BAUD) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BAUD) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (BAUD) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  // Reference model: word i of the packet is slice (WPB-1 - i%WPB) of byte i/WPB
  task automatic expect_writes(input logic [7:0] start, input logic [7:0] cnt, input int limit);
    int  n;
    wr_t w;
    n = (cnt == 0) ? (1 << AW) : int'(cnt);
    if (limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      w.addr = AW'((int'(start) + i) % (1 << AW));
      w.data = DW'(int'(pkt[i / WPB]) >> ((WPB - 1 - (i % WPB)) * DW));
      exp_q.push_back(w);
    end
  endtask

  task automatic send_packet(input logic [7:0] start, input logic [7:0] cnt,
                             input bit good, input bit glitch);
    int         sum;
    logic [7:0] cs;
    sum = int'(start) + int'(cnt);
    foreach (pkt[i]) sum += int'(pkt[i]);
    cs = 8'(sum % 256);
    if (!good) cs = cs ^ 8'h5A;
    expect_writes(start, cnt, 1 << 30);
    send_byte(8'hA5, 1'b1);
    if (glitch) begin
      rx_i = 1'b0;
      repeat (5) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2 * BAUD) @(negedge clk_i);
    end
    send_byte(start, 1'b1);
    send_byte(cnt, 1'b1);
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    send_byte(cs, 1'b1);
    if (good) begin
      exp_done++;
      exp_err = 2'd0;
    end else begin
      exp_err = 2'd2;
    end
  endtask

  task automatic finish_packet(input string tag);
    repeat (BAUD) @(negedge clk_i);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_done"}, done_seen, exp_done);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic rand_packet(output logic [7:0] start, output logic [7:0] cnt);
    int n;
    start = 8'($urandom_range(0, 255));
    cnt   = 8'($urandom_range(0, 20));
    n     = (cnt == 0) ? (1 << AW) : int'(cnt);
    pkt.delete();
    for (int i = 0; i < (n + WPB - 1) / WPB; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] st, cn;
    bit         got;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_prog", program_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_strb_o, 0);
    chk("rst_err", err_o, 0);
    reset_i     = 1'b1;
    p_program_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("prog_mirror", program_o, 1);

    // Full 16-word packet, COUNT=0x10
    pkt = '{8'hE0, 8'hCF, 8'h4F, 8'hAA, 8'h81, 8'h4E, 8'h60, 8'h01};
    send_packet(8'h00, 8'h10, 1'b1, 1'b0);
    finish_packet("pkt16");

    // Odd count with address wrap
    pkt = '{8'h12, 8'h30};
    send_packet(8'h0E, 8'h03, 1'b1, 1'b0);
    finish_packet("wrap");

    // Same packet, bad checksum: writes still happen
    send_packet(8'h0E, 8'h03, 1'b0, 1'b0);
    finish_packet("badcs");

    // Random packets, including COUNT=0 and counts beyond the depth
    for (int r = 0; r < 5; r++) begin
      rand_packet(st, cn);
      send_packet(st, cn, 1'b1, 1'b0);
      finish_packet("rand");
    end

    // Short low pulse after SYNC must not be taken as the address byte
    pkt = '{8'h12, 8'h30};
    send_packet(8'h0E, 8'h03, 1'b1, 1'b1);
    finish_packet("glitch");

    // Inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    chk("to_busy_open", busy_o, 1);
    repeat (38 * BAUD) @(negedge clk_i);
    chk("to_not_early", busy_o, 1);
    repeat (3 * BAUD) @(negedge clk_i);
    exp_err = 2'd3;
    chk("to_busy", busy_o, 0);
    chk("to_err", err_o, exp_err);
    chk("to_pending", exp_q.size(), 0);

    // Framing error in DATA
    pkt = '{8'h9C};
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    expect_writes(8'h00, 8'h04, 2);
    send_byte(8'h9C, 1'b1);
    send_byte(8'h33, 1'b0);
    exp_err = 2'd1;
    finish_packet("frame");

    // Good packet clears the error
    rand_packet(st, cn);
    send_packet(st, cn, 1'b1, 1'b0);
    finish_packet("clear");

    // Abort during a write burst: only the first slice may be written
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h04, 1'b1);
    pkt = '{8'hB7};
    expect_writes(8'h02, 8'h04, 1);
    got = 1'b0;
    fork
      send_byte(8'hB7, 1'b1);
      begin
        for (int k = 0; k < 12 * BAUD; k++) begin
          @(negedge clk_i);
          if (mem_we_o) begin
            got = 1'b1;
            p_program_i = 1'b0;
            break;
          end
        end
        if (got) begin
          @(negedge clk_i);
          chk("abort_we", mem_we_o, 0);
          chk("abort_prog", program_o, 0);
          chk("abort_busy", busy_o, 0);
        end
      end
    join
    chk("abort_we_seen", got, 1);
    exp_err = 2'd3;
    chk("abort_err", err_o, exp_err);
    chk("abort_pending", exp_q.size(), 0);
    p_program_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Asynchronous reset in the middle of a byte
    rx_i = 1'b0;
    repeat (3 * BAUD) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("arst_we", mem_we_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    chk("arst_data", mem_data_o, 0);
    chk("arst_prog", program_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_strb_o, 0);
    chk("arst_err", err_o, 0);
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    reset_i = 1'b1;
    exp_err = 2'd0;
    repeat (4) @(negedge clk_i);

    // Loader works normally after reset
    rand_packet(st, cn);
    send_packet(st, cn, 1'b1, 1'b0);
    finish_packet("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
